multi_key_press_classifier: RTL and testbench
=============================================

// Module: multi_key_press_classifier
// PURPOSE
//  N-channel key front end: synchronises, debounces and classifies each raw key
//  input into short press, long press and (optional) auto-repeat events. Sits
//  between board push-buttons and the game/UI control logic. It supersedes the
//  single-channel long/short detector with a debounce stage, parametrised
//  thresholds, per-channel FSMs and registered one-cycle event pulses.
// PARAMETERS
//  N_CH      4     number of independent key channels (>=1)
//  DEB_CYC   16    consecutive stable samples needed to accept a level change (>=1)
//  LONG_CYC  100   cycles of debounced-high before a press counts as long (>=2)
//  REP_CYC   25    auto-repeat period in cycles, used only with AUTO_REPEAT_EN (>=1)
// PORTS
//  clk          in   1     system clock
//  rst          in   1     synchronous reset, active-high
//  key_raw      in   N_CH  asynchronous raw key levels, 1 = pressed
//  pressed_lv   out  N_CH  debounced key level
//  short_pulse  out  N_CH  1-cycle pulse on release of a short press
//  long_pulse   out  N_CH  1-cycle pulse when a press becomes long
//  long_lv      out  N_CH  high while a long press is held
//  repeat_pulse out  N_CH  1-cycle auto-repeat pulse (tied 0 without AUTO_REPEAT_EN)
// BEHAVIOUR
//  - Single clock domain clk; rst is synchronous, active-high. Channels fully
//    independent; simultaneous activity on any channel mix is legal.
//  - Reset: every output 0; sync flops, debounced level, all counters 0; FSM IDLE.
//    A key held through reset is treated as a new press after debounce.
//  - Sync: key_raw -> 2-flop synchroniser -> key_s (2-cycle latency).
//  - Debounce: deb_cnt (clog2(DEB_CYC+1) bits). key_s == stable -> deb_cnt=0.
//    key_s != stable -> deb_cnt++; on reaching DEB_CYC: stable flips, deb_cnt=0.
//    Glitches shorter than DEB_CYC cycles never change stable.
//    pressed_lv = stable (registered).
//  - Per-channel FSM on stable; hold_cnt saturates at LONG_CYC:
//    IDLE : stable=1 -> PRESS, hold_cnt=1.
//    PRESS: stable=0 -> IDLE, short_pulse=1 next cycle.
//           stable=1 & hold_cnt==LONG_CYC-1 -> LONG, long_pulse=1 next cycle.
//           else hold_cnt++.
//    LONG : long_lv=1; stable=0 -> IDLE, long_lv=0 next cycle, no short_pulse.
//  - Net: stable high for N cycles, 1<=N<LONG_CYC -> exactly one short_pulse;
//    N>=LONG_CYC -> exactly one long_pulse, never a short_pulse.
//    long_pulse and long_lv rise on the same cycle.
//  - Event outputs registered: 1-cycle pulses, never asserted 2 cycles running
//    (except repeat_pulse when REP_CYC==1).
//  - Latency: raw edge -> pressed_lv edge = 2 + DEB_CYC + 1 cycles.
//  - Reset mid-press: FSM to IDLE, no pulse emitted for the aborted press.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: in LONG, rep_cnt counts 1..REP_CYC; repeat_pulse=1
//    each time rep_cnt wraps. First repeat REP_CYC cycles after long_pulse.
//    rep_cnt cleared on LONG exit and on reset.
//  AUTO_REPEAT_EN undefined: no rep_cnt logic; repeat_pulse driven constant 0.
// TESTING (N_CH=2, DEB_CYC=4, LONG_CYC=10, REP_CYC=5)
//  1 rst=1 4 cycles, key_raw=2'b11 -> all outputs 0; after rst drop, pressed_lv
//    rises 7 cycles later (fresh press).
//  2 ch0 glitch high 3 cycles -> pressed_lv, short_pulse, long_pulse stay 0.
//  3 ch0 debounced high 6 cycles then low -> one short_pulse; no long_pulse.
//  4 ch1 debounced high 25 cycles -> one long_pulse on the cycle long_lv rises;
//    long_lv holds until release; no short_pulse; with AUTO_REPEAT_EN:
//    repeat_pulse every 5 cycles after long_pulse; without: repeat_pulse=0.
//  5 ch0 short + ch1 long overlapping -> each channel's events as in 3 and 4,
//    no cross-talk.
//  6 rst pulsed at hold_cnt=7 on ch0 -> no pulse for that press; key still held
//    -> new press detected after debounce.

Source files
------------

// File: rtl/multi_key_press_classifier.sv
// N-channel key front end: 2-flop sync, debounce and short/long/auto-repeat classification.
// Optional feature macro: AUTO_REPEAT_EN (enables repeat_pulse generation while a long press is held).
module multi_key_press_classifier #(
  parameter int N_CH     = 4,
  parameter int DEB_CYC  = 16,
  parameter int LONG_CYC = 100,
  parameter int REP_CYC  = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] key_raw,
  output logic [N_CH-1:0] pressed_lv,
  output logic [N_CH-1:0] short_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] long_lv,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  // Elaboration-time guard against unusable threshold values.
  if (N_CH < 1 || DEB_CYC < 1 || LONG_CYC < 2 || REP_CYC < 1) begin : g_param_check
    $error("multi_key_press_classifier: illegal parameter value");
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic             sync1_reg;
    logic             key_s_reg;
    logic             stable_reg;
    logic             pressed_reg;
    logic [DEB_W-1:0] deb_cnt_reg;

    state_t            state_reg, state_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              short_reg, short_next;
    logic              long_pulse_reg, long_pulse_next;
    logic              long_lv_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_reg   <= 1'b0;
        key_s_reg   <= 1'b0;
        stable_reg  <= 1'b0;
        pressed_reg <= 1'b0;
        deb_cnt_reg <= '0;
      end else begin
        sync1_reg   <= key_raw[gi];
        key_s_reg   <= sync1_reg;
        pressed_reg <= stable_reg;
        // Any agreeing sample restarts the count, so short glitches never flip stable.
        if (key_s_reg == stable_reg) begin
          deb_cnt_reg <= '0;
        end else if (deb_cnt_reg == DEB_LAST) begin
          stable_reg  <= ~stable_reg;
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end
    end

    always_comb begin
      state_next      = state_reg;
      hold_cnt_next   = hold_cnt_reg;
      short_next      = 1'b0;
      long_pulse_next = 1'b0;
      case (state_reg)
        IDLE: begin
          if (stable_reg) begin
            state_next    = PRESS;
            hold_cnt_next = HOLD_W'(1);
          end
        end
        PRESS: begin
          if (!stable_reg) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
            short_next    = 1'b1;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            state_next      = LONG;
            hold_cnt_next   = HOLD_SAT;
            long_pulse_next = 1'b1;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        LONG: begin
          if (!stable_reg) begin
            state_next    = IDLE;
            hold_cnt_next = '0;
          end
        end
        default: begin
          state_next    = IDLE;
          hold_cnt_next = '0;
        end
      endcase
    end

    // long_lv follows the next state so it rises together with long_pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg      <= IDLE;
        hold_cnt_reg   <= '0;
        short_reg      <= 1'b0;
        long_pulse_reg <= 1'b0;
        long_lv_reg    <= 1'b0;
      end else begin
        state_reg      <= state_next;
        hold_cnt_reg   <= hold_cnt_next;
        short_reg      <= short_next;
        long_pulse_reg <= long_pulse_next;
        long_lv_reg    <= (state_next == LONG);
      end
    end

    assign pressed_lv[gi]  = pressed_reg;
    assign short_pulse[gi] = short_reg;
    assign long_pulse[gi]  = long_pulse_reg;
    assign long_lv[gi]     = long_lv_reg;

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = (REP_CYC > 1) ? $clog2(REP_CYC) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CYC - 1);

    logic [REP_W-1:0] rep_cnt_reg;
    logic             rep_pulse_reg;

    // Counts held-long cycles; first wrap lands REP_CYC cycles after long_pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        rep_cnt_reg   <= '0;
        rep_pulse_reg <= 1'b0;
      end else if (state_reg == LONG && stable_reg) begin
        if (rep_cnt_reg == REP_LAST) begin
          rep_cnt_reg   <= '0;
          rep_pulse_reg <= 1'b1;
        end else begin
          rep_cnt_reg   <= rep_cnt_reg + 1'b1;
          rep_pulse_reg <= 1'b0;
        end
      end else begin
        rep_cnt_reg   <= '0;
        rep_pulse_reg <= 1'b0;
      end
    end

    assign repeat_pulse[gi] = rep_pulse_reg;
`else
    assign repeat_pulse[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multi_key_press_classifier.sv
// Self-checking bench for multi_key_press_classifier: directed steps plus random key traffic
// checked every cycle against a run-length reference model.
module tb_multi_key_press_classifier;

  localparam int N_CH     = 2;
  localparam int DEB_CYC  = 4;
  localparam int LONG_CYC = 10;
  localparam int REP_CYC  = 5;

`ifdef AUTO_REPEAT_EN
  localparam int EXP_REP_T4 = 3;
`else
  localparam int EXP_REP_T4 = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] key_raw;
  logic [N_CH-1:0] pressed_lv;
  logic [N_CH-1:0] short_pulse;
  logic [N_CH-1:0] long_pulse;
  logic [N_CH-1:0] long_lv;
  logic [N_CH-1:0] repeat_pulse;

  always #5 clk = ~clk;

  multi_key_press_classifier #(
    .N_CH    (N_CH),
    .DEB_CYC (DEB_CYC),
    .LONG_CYC(LONG_CYC),
    .REP_CYC (REP_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_raw     (key_raw),
    .pressed_lv  (pressed_lv),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .long_lv     (long_lv),
    .repeat_pulse(repeat_pulse)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw samples delayed two edges, run length of disagreeing
  // samples for debounce, run length of debounced-high cycles for classification.
  logic [N_CH-1:0] m_d1, m_d2, m_stable;
  logic [N_CH-1:0] m_pressed, m_short, m_long, m_long_lv, m_rep;
  int m_run [N_CH];
  int m_len [N_CH];

  int cnt_short [N_CH];
  int cnt_long  [N_CH];
  int cnt_rep   [N_CH];
  int cnt_lv    [N_CH];

  task automatic check(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0;
      m_pressed = '0; m_short = '0; m_long = '0; m_long_lv = '0; m_rep = '0;
      for (int c = 0; c < N_CH; c++) begin
        m_run[c] = 0;
        m_len[c] = 0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        m_pressed[c] = m_stable[c];
        m_short[c] = 1'b0;
        m_long[c]  = 1'b0;
        m_rep[c]   = 1'b0;
        if (m_stable[c]) begin
          m_len[c]++;
          if (m_len[c] == LONG_CYC) m_long[c] = 1'b1;
`ifdef AUTO_REPEAT_EN
          if (m_len[c] > LONG_CYC && (m_len[c] - LONG_CYC) % REP_CYC == 0) m_rep[c] = 1'b1;
`endif
        end else begin
          if (m_len[c] > 0 && m_len[c] < LONG_CYC) m_short[c] = 1'b1;
          m_len[c] = 0;
        end
        m_long_lv[c] = (m_len[c] >= LONG_CYC);
        if (m_d2[c] != m_stable[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB_CYC) begin
            m_stable[c] = ~m_stable[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_d2[c] = m_d1[c];
        m_d1[c] = key_raw[c];
      end
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N_CH; c++) begin
      cnt_short[c] = 0;
      cnt_long[c]  = 0;
      cnt_rep[c]   = 0;
      cnt_lv[c]    = 0;
    end
  endtask

  // One clock cycle: drive on negedge, model the posedge, compare 1 time unit later.
  task automatic step(input logic [N_CH-1:0] k, input logic r);
    @(negedge clk);
    key_raw = k;
    rst     = r;
    @(posedge clk);
    model_edge();
    #1;
    check("pressed_lv", pressed_lv, m_pressed);
    check("short_pulse", short_pulse, m_short);
    check("long_pulse", long_pulse, m_long);
    check("long_lv", long_lv, m_long_lv);
    check("repeat_pulse", repeat_pulse, m_rep);
    for (int c = 0; c < N_CH; c++) begin
      cnt_short[c] += int'(short_pulse[c]);
      cnt_long[c]  += int'(long_pulse[c]);
      cnt_rep[c]   += int'(repeat_pulse[c]);
      cnt_lv[c]    += int'(pressed_lv[c]);
    end
  endtask

  task automatic hold(input logic [N_CH-1:0] k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b0);
  endtask

  initial begin
    int lat;
    logic [N_CH-1:0] lvl;
    int remain [N_CH];

    key_raw = '0;
    rst     = 1'b1;
    clear_counts();

    // 1: reset with keys held; then a fresh press appears after sync + debounce
    for (int i = 0; i < 4; i++) step(2'b11, 1'b1);
    check_int("rst_all_zero", int'({pressed_lv, short_pulse, long_pulse, long_lv, repeat_pulse}), 0);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step(2'b11, 1'b0);
      if (lat < 0 && pressed_lv[0]) lat = i;
    end
    check_int("t1_press_latency", lat, 2 + DEB_CYC + 1);
    hold(2'b00, 30);

    // 2: glitch shorter than DEB_CYC
    clear_counts();
    hold(2'b01, 3);
    hold(2'b00, 15);
    check_int("t2_glitch_lv", cnt_lv[0], 0);
    check_int("t2_glitch_short", cnt_short[0], 0);
    check_int("t2_glitch_long", cnt_long[0], 0);

    // 3: short press, plus boundary lengths DEB_CYC and LONG_CYC-1
    clear_counts();
    hold(2'b01, 6);
    hold(2'b00, 15);
    check_int("t3_short", cnt_short[0], 1);
    check_int("t3_no_long", cnt_long[0], 0);
    clear_counts();
    hold(2'b01, DEB_CYC);
    hold(2'b00, 15);
    check_int("t3_min_short", cnt_short[0], 1);
    clear_counts();
    hold(2'b01, LONG_CYC - 1);
    hold(2'b00, 15);
    check_int("t3_edge_short", cnt_short[0], 1);
    check_int("t3_edge_no_long", cnt_long[0], 0);
    clear_counts();
    hold(2'b01, LONG_CYC);
    hold(2'b00, 15);
    check_int("t3_edge_long", cnt_long[0], 1);
    check_int("t3_edge_no_short", cnt_short[0], 0);

    // 4: long press with optional auto-repeat
    clear_counts();
    hold(2'b10, 25);
    hold(2'b00, 20);
    check_int("t4_long", cnt_long[1], 1);
    check_int("t4_no_short", cnt_short[1], 0);
    check_int("t4_repeat", cnt_rep[1], EXP_REP_T4);

    // 5: overlapping short on ch0 and long on ch1
    clear_counts();
    hold(2'b11, 6);
    hold(2'b10, 19);
    hold(2'b00, 20);
    check_int("t5_ch0_short", cnt_short[0], 1);
    check_int("t5_ch0_long", cnt_long[0], 0);
    check_int("t5_ch1_long", cnt_long[1], 1);
    check_int("t5_ch1_short", cnt_short[1], 0);

    // 6: reset mid-press on ch0; held key re-detected as a new (short) press
    clear_counts();
    hold(2'b01, 13);
    step(2'b01, 1'b1);
    hold(2'b01, 8);
    hold(2'b00, 20);
    check_int("t6_short_after_rst", cnt_short[0], 1);
    check_int("t6_no_long", cnt_long[0], 0);

    // Random traffic with occasional resets, checked cycle by cycle
    lvl = '0;
    for (int c = 0; c < N_CH; c++) remain[c] = 1;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        remain[c]--;
        if (remain[c] <= 0) begin
          lvl[c] = ~lvl[c];
          remain[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEB_CYC))
                                                  : int'($urandom_range(1, 3 * LONG_CYC));
        end
      end
      step(lvl, ($urandom_range(0, 299) == 0));
    end
    hold(2'b00, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
